sb_arbiter: RTL and testbench

SB_ARBITER -- requirements
Module: sb_arbiter

---
 rtl/sb_arbiter.sv | 116 +++++++++++
 tb/tb_sb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sb_arbiter.sv
// Two-master system bus arbiter with lock, split parking and handover.
// Ports: sb_clk/sb_resetn, busreq/lock per master, owner trans, slave ready/resp/split -> grants, sb_master, sb_mastlock, sb_split_mask.
// Optional macro SB_ARB_ROUND_ROBIN_EN: contention goes to the master not most recently granted.
module sb_arbiter #(
    parameter bit DEFAULT_PRIO = 1'b1
) (
    input  logic       sb_clk,
    input  logic       sb_resetn,
    input  logic       sb_busreq_m1,
    input  logic       sb_busreq_m2,
    input  logic       sb_lock_m1,
    input  logic       sb_lock_m2,
    input  logic [1:0] sb_trans,
    input  logic       sb_ready,
    input  logic [1:0] sb_resp,
    input  logic [1:0] sb_split,
    output logic       sb_grant_m1,
    output logic       sb_grant_m2,
    output logic       sb_master,
    output logic       sb_mastlock,
    output logic [1:0] sb_split_mask
);

    localparam logic [1:0] TRANS_IDLE = 2'd0;
    localparam logic [1:0] RESP_SPLIT = 2'd3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWN_M1 = 2'd1,
        ARB_OWN_M2 = 2'd2
    } arb_state_e;

    arb_state_e state_q;

    logic       own_m1;
    logic       own_m2;
    logic       split_rsp;
    logic       owner_free;
    logic       rearb;
    logic       any_elig;
    logic       prio_m1;
    logic       win_m1;
    logic [1:0] set_mask;
    logic [1:0] mask_d;
    logic [1:0] elig;

    assign own_m1    = (state_q == ARB_OWN_M1);
    assign own_m2    = (state_q == ARB_OWN_M2);
    assign split_rsp = sb_ready && (sb_resp == RESP_SPLIT) && (own_m1 || own_m2);

    // A split set in the same cycle as a release for that master wins.
    assign set_mask = {own_m2 & split_rsp, own_m1 & split_rsp};
    assign mask_d   = (sb_split_mask & ~sb_split) | set_mask;
    assign elig     = {sb_busreq_m2, sb_busreq_m1} & ~mask_d;
    assign any_elig = |elig;

    assign owner_free = sb_ready && (sb_trans == TRANS_IDLE)
                     && !(own_m1 ? sb_lock_m1 : sb_lock_m2);

    // Arbitration happens from idle, on a split, or at the owner's handover point.
    assign rearb = (state_q == ARB_IDLE) || split_rsp || owner_free;

`ifdef SB_ARB_ROUND_ROBIN_EN
    // 1 = M1 preferred on the next tie.
    logic prio_q;
    assign prio_m1 = prio_q;
`else
    assign prio_m1 = DEFAULT_PRIO;
`endif

    assign win_m1 = elig[0] && (!elig[1] || prio_m1);

    always_ff @(posedge sb_clk or negedge sb_resetn) begin
        if (!sb_resetn) begin
            state_q       <= ARB_IDLE;
            sb_grant_m1   <= 1'b0;
            sb_grant_m2   <= 1'b0;
            sb_master     <= 1'b1;
            sb_mastlock   <= 1'b0;
            sb_split_mask <= 2'b00;
`ifdef SB_ARB_ROUND_ROBIN_EN
            prio_q        <= DEFAULT_PRIO;
`endif
        end else begin
            sb_split_mask <= mask_d;
            if (rearb) begin
                if (!any_elig) begin
                    state_q     <= ARB_IDLE;
                    sb_grant_m1 <= 1'b0;
                    sb_grant_m2 <= 1'b0;
                    sb_mastlock <= 1'b0;
                end else if (win_m1) begin
                    state_q     <= ARB_OWN_M1;
                    sb_grant_m1 <= 1'b1;
                    sb_grant_m2 <= 1'b0;
                    sb_master   <= 1'b1;
                    sb_mastlock <= split_rsp ? 1'b0 : sb_lock_m1;
                end else begin
                    state_q     <= ARB_OWN_M2;
                    sb_grant_m1 <= 1'b0;
                    sb_grant_m2 <= 1'b1;
                    sb_master   <= 1'b0;
                    sb_mastlock <= split_rsp ? 1'b0 : sb_lock_m2;
                end
`ifdef SB_ARB_ROUND_ROBIN_EN
                if (any_elig) begin
                    prio_q <= !win_m1;
                end
`endif
            end else begin
                sb_mastlock <= own_m1 ? sb_lock_m1 : sb_lock_m2;
            end
        end
    end

endmodule

// File: tb/tb_sb_arbiter.sv
// Scoreboard bench for sb_arbiter: driver pushes model expectations,
// monitor pops and compares one cycle later.
module tb_sb_arbiter;

    localparam bit DP = 1'b1;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_NSEQ = 2'd2;
    localparam logic [1:0] T_SEQ  = 2'd3;
    localparam logic [1:0] R_OKAY = 2'd1;
    localparam logic [1:0] R_ERR  = 2'd2;
    localparam logic [1:0] R_SPL  = 2'd3;

    logic       clk = 1'b0;
    logic       rn = 1'b0;
    logic       r1 = 1'b0, r2 = 1'b0, l1 = 1'b0, l2 = 1'b0, rdy = 1'b0;
    logic [1:0] tr = 2'd0, rsp = 2'd0, spl = 2'd0;
    logic       g1, g2, mst, mlk;
    logic [1:0] msk;

    sb_arbiter #(.DEFAULT_PRIO(DP)) dut (
        .sb_clk        (clk),
        .sb_resetn     (rn),
        .sb_busreq_m1  (r1),
        .sb_busreq_m2  (r2),
        .sb_lock_m1    (l1),
        .sb_lock_m2    (l2),
        .sb_trans      (tr),
        .sb_ready      (rdy),
        .sb_resp       (rsp),
        .sb_split      (spl),
        .sb_grant_m1   (g1),
        .sb_grant_m2   (g2),
        .sb_master     (mst),
        .sb_mastlock   (mlk),
        .sb_split_mask (msk)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       g1;
        logic       g2;
        logic       mst;
        logic       lk;
        logic [1:0] msk;
    } exp_t;

    exp_t q[$];
    exp_t mon_e, mon_a;
    int   passed = 0;
    int   total  = 0;

    // Reference model: owner 0 = nobody, 1 = M1, 2 = M2.
    int owner;
    int pref;
    bit master_m;
    bit lock_m;
    bit parked[1:2];

    task automatic model_reset();
        owner     = 0;
        master_m  = 1'b1;
        lock_m    = 1'b0;
        parked[1] = 1'b0;
        parked[2] = 1'b0;
        pref      = DP ? 1 : 2;
    endtask

    task automatic drive(input bit rn_v, input bit b1, input bit b2,
                         input bit k1, input bit k2, input logic [1:0] t,
                         input bit rd, input logic [1:0] rs,
                         input logic [1:0] sp);
        int   hit;
        int   pick;
        bit   want[1:2];
        bit   lk[0:2];
        bit   decide;
        exp_t e;
        @(negedge clk);
        rn = rn_v; r1 = b1; r2 = b2; l1 = k1; l2 = k2;
        tr = t; rdy = rd; rsp = rs; spl = sp;
        if (!rn_v) begin
            model_reset();
        end else begin
            lk[0] = 1'b0; lk[1] = k1; lk[2] = k2;
            hit = (owner != 0 && rd && rs == R_SPL) ? owner : 0;
            for (int m = 1; m <= 2; m++) begin
                if (sp[m-1]) parked[m] = 1'b0;
                if (hit == m) parked[m] = 1'b1;
            end
            want[1] = b1 && !parked[1];
            want[2] = b2 && !parked[2];
            decide = (owner == 0) || (hit != 0)
                  || (rd && t == T_IDLE && !lk[owner]);
            if (decide) begin
                if (want[1] && want[2]) pick = pref;
                else if (want[1])       pick = 1;
                else if (want[2])       pick = 2;
                else                    pick = 0;
`ifdef SB_ARB_ROUND_ROBIN_EN
                if (pick != 0) pref = 3 - pick;
`endif
                owner  = pick;
                lock_m = (pick != 0 && hit == 0) ? lk[pick] : 1'b0;
            end else begin
                lock_m = lk[owner];
            end
            if (owner != 0) master_m = (owner == 1);
        end
        e.g1  = (owner == 1);
        e.g2  = (owner == 2);
        e.mst = master_m;
        e.lk  = lock_m;
        e.msk = {parked[2], parked[1]};
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            mon_a = '{g1: g1, g2: g2, mst: mst, lk: mlk, msk: msk};
            total++;
            if (mon_a == mon_e) passed++;
            else $display("FAIL outputs t=%0t got g1g2=%b%b mst=%b lk=%b msk=%b want g1g2=%b%b mst=%b lk=%b msk=%b",
                          $time, mon_a.g1, mon_a.g2, mon_a.mst, mon_a.lk, mon_a.msk,
                          mon_e.g1, mon_e.g2, mon_e.mst, mon_e.lk, mon_e.msk);
        end
    end

    initial begin
        int rr;
        bit rn_r;
        logic [1:0] rs_r, sp_r;
        model_reset();
        drive(0, 0, 0, 0, 0, T_IDLE, 1, R_OKAY, 2'b00);
        drive(0, 0, 0, 0, 0, T_IDLE, 1, R_OKAY, 2'b00);
        drive(1, 0, 0, 0, 0, T_IDLE, 1, R_OKAY, 2'b00);
        drive(1, 1, 0, 0, 0, T_IDLE, 1, R_OKAY, 2'b00);
        // Locked M1 blocks M2 at the handover point.
        drive(1, 1, 1, 1, 0, T_NSEQ, 1, R_OKAY, 2'b00);
        drive(1, 1, 1, 1, 0, T_IDLE, 1, R_OKAY, 2'b00);
        drive(1, 1, 1, 1, 0, T_IDLE, 1, R_OKAY, 2'b00);
        drive(1, 0, 1, 0, 0, T_IDLE, 1, R_OKAY, 2'b00);
        // M2 split, M1 takes over, then M2 released.
        drive(1, 1, 1, 0, 0, T_NSEQ, 1, R_OKAY, 2'b00);
        drive(1, 1, 1, 0, 0, T_NSEQ, 1, R_SPL,  2'b00);
        drive(1, 1, 1, 0, 0, T_NSEQ, 1, R_OKAY, 2'b10);
        // Both parked, then set beats release.
        drive(1, 1, 1, 0, 0, T_NSEQ, 1, R_SPL,  2'b00);
        drive(1, 1, 1, 0, 0, T_NSEQ, 1, R_SPL,  2'b00);
        drive(1, 1, 1, 0, 0, T_IDLE, 1, R_ERR,  2'b00);
        drive(1, 1, 0, 0, 0, T_IDLE, 1, R_OKAY, 2'b01);
        drive(1, 1, 0, 0, 0, T_NSEQ, 1, R_SPL,  2'b01);
        drive(1, 0, 0, 0, 0, T_IDLE, 1, R_OKAY, 2'b11);
        // Continuous contention with a handover every cycle.
        repeat (6) drive(1, 1, 1, 0, 0, T_IDLE, 1, R_OKAY, 2'b00);
        // Asynchronous reset while M1 owns locked with M2 parked.
        drive(0, 0, 0, 0, 0, T_IDLE, 1, R_OKAY, 2'b00);
        drive(1, 0, 1, 0, 0, T_IDLE, 1, R_OKAY, 2'b00);
        drive(1, 0, 1, 0, 0, T_NSEQ, 1, R_SPL,  2'b00);
        drive(1, 1, 0, 1, 0, T_NSEQ, 1, R_OKAY, 2'b00);
        drive(1, 1, 0, 1, 0, T_SEQ,  0, R_OKAY, 2'b00);
        drive(0, 1, 0, 1, 0, T_SEQ,  1, R_OKAY, 2'b00);
        #1;
        total++;
        if ({g1, g2, mst, mlk, msk} == 6'b001000) passed++;
        else $display("FAIL async_reset got g1g2=%b%b mst=%b lk=%b msk=%b want 00 1 0 00",
                      g1, g2, mst, mlk, msk);
        drive(1, 0, 0, 0, 0, T_IDLE, 1, R_OKAY, 2'b00);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rn_r = ($urandom_range(99) != 0);
            rr   = $urandom_range(9);
            rs_r = (rr == 0) ? R_SPL : (rr == 1) ? R_ERR : R_OKAY;
            sp_r = ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'b00;
            drive(rn_r, $urandom_range(9) < 7, $urandom_range(9) < 7,
                  $urandom_range(9) < 2, $urandom_range(9) < 2,
                  2'($urandom_range(3)), $urandom_range(4) != 0, rs_r, sp_r);
        end
        drive(1, 0, 0, 0, 0, T_IDLE, 1, R_OKAY, 2'b00);
        @(posedge clk);
        #2;
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain got %0d pending want 0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
